// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with valid/ready handshake, iterative shifts/multiply, NZVC flags
module alu_seq #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       cntrl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             set_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             err,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [3:0] OP_MOV = 4'b0000, OP_ADD = 4'b0010, OP_SUB = 4'b0011,
                           OP_AND = 4'b0100, OP_OR = 4'b0101, OP_XOR = 4'b0110,
                           OP_LSL = 4'b1000, OP_LSR = 4'b1001, OP_MUL = 4'b1010;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL, S_DONE} state_t;

    state_t           state_q;
    logic [3:0]       op_q;
    logic             sf_q;
    logic [WIDTH-1:0] a_q, b_q, acc_q, result_q;
    logic [SHW:0]     cnt_q;
    logic             err_q, n_q, z_q, v_q, c_q;

    logic [WIDTH:0]   sum, dif;
    logic [WIDTH-1:0] sc_res, sh_d, acc_d, res_d;
    logic             sc_c, sc_v, sc_ill, sh_c, go_long, fin_d, c_d, v_d, upd_d, err_d;

    // single-cycle datapath on the request operands plus next values for the iterative ops
    always_comb begin
        sum    = {1'b0, A} + {1'b0, B};
        dif    = {1'b0, A} + {1'b0, ~B} + (WIDTH+1)'(1);
        sc_res = '0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        sc_ill = 1'b0;
        case (cntrl)
            OP_MOV: sc_res = B;
            OP_ADD: begin
                sc_res = sum[WIDTH-1:0];
                sc_c   = sum[WIDTH];
                sc_v   = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = dif[WIDTH-1:0];
                sc_c   = dif[WIDTH];
                sc_v   = (A[WIDTH-1] != B[WIDTH-1]) && (dif[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND: sc_res = A & B;
            OP_OR:  sc_res = A | B;
            OP_XOR: sc_res = A ^ B;
            OP_LSL, OP_LSR: sc_res = A;
            OP_MUL: sc_res = '0;
            default: sc_ill = 1'b1;
        endcase
        sh_d    = (op_q == OP_LSL) ? a_q << 1 : a_q >> 1;
        sh_c    = (op_q == OP_LSL) ? a_q[WIDTH-1] : a_q[0];
        acc_d   = acc_q + (b_q[0] ? a_q : '0);
        go_long = (cntrl == OP_MUL) || (((cntrl == OP_LSL) || (cntrl == OP_LSR)) && (B[SHW-1:0] != '0));
        fin_d   = ((state_q == S_IDLE) && in_valid && !go_long) ||
                  (((state_q == S_SHIFT) || (state_q == S_MUL)) && (cnt_q == (SHW+1)'(1)));
        res_d   = (state_q == S_SHIFT) ? sh_d : (state_q == S_MUL) ? acc_d : sc_res;
        c_d     = (state_q == S_SHIFT) ? sh_c : (state_q == S_MUL) ? 1'b0 : sc_c;
        v_d     = (state_q == S_IDLE) && sc_v;
        upd_d   = (state_q == S_IDLE) ? (set_flags && !sc_ill) : sf_q;
        err_d   = (state_q == S_IDLE) && sc_ill;
    end

    // control FSM with operand/counter registers, registered result and flag register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            sf_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
            v_q      <= 1'b0;
            c_q      <= 1'b0;
        end else begin
            if (fin_d) begin
                result_q <= res_d;
                err_q    <= err_d;
                if (upd_d) begin
                    n_q <= res_d[WIDTH-1];
                    z_q <= (res_d == '0);
                    v_q <= v_d;
                    c_q <= c_d;
                end
            end
            case (state_q)
                S_IDLE: if (in_valid) begin
                    op_q    <= cntrl;
                    sf_q    <= set_flags;
                    a_q     <= A;
                    b_q     <= B;
                    acc_q   <= '0;
                    cnt_q   <= (cntrl == OP_MUL) ? (SHW+1)'(WIDTH) : {1'b0, B[SHW-1:0]};
                    state_q <= (cntrl == OP_MUL) ? S_MUL : go_long ? S_SHIFT : S_DONE;
                end
                S_SHIFT: begin
                    a_q   <= sh_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (fin_d) state_q <= S_DONE;
                end
                S_MUL: begin
                    a_q   <= a_q << 1;
                    b_q   <= b_q >> 1;
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (fin_d) state_q <= S_DONE;
                end
                default: if (out_ready) state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign err       = err_q;
    assign negative  = n_q;
    assign zero      = z_q;
    assign overflow  = v_q;
    assign carry_out = c_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed-vector self-checking bench for alu_seq (WIDTH=64)
module tb_alu_seq;
    logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0, set_flags = 1'b0;
    logic [3:0]  cntrl = '0;
    logic [63:0] A = '0, B = '0;
    logic        in_ready, out_valid, err, negative, zero, overflow, carry_out;
    logic [63:0] result;
    int          n_cmp = 0, n_bad = 0;

    alu_seq #(.WIDTH(64)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .cntrl(cntrl),
        .A(A), .B(B), .set_flags(set_flags), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .err(err), .negative(negative), .zero(zero), .overflow(overflow),
        .carry_out(carry_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] nzvc();
        return {negative, zero, overflow, carry_out};
    endfunction

    task automatic run_op(input string tag, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic sf, input int exp_lat, input logic [63:0] exp_res,
                          input logic [3:0] exp_f, input logic exp_err);
        int   lat = 0;
        int   w = 0;
        logic busy_rdy;
        while (!in_ready && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        check({tag, "/ready"}, {63'd0, in_ready}, 64'd1);
        cntrl = op; A = a; B = b; set_flags = sf; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        busy_rdy = in_ready;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            busy_rdy |= in_ready;
        end
        check({tag, "/lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "/res"}, result, exp_res);
        check({tag, "/err"}, {63'd0, err}, {63'd0, exp_err});
        check({tag, "/nzvc"}, {60'd0, nzvc()}, {60'd0, exp_f});
        check({tag, "/busy_rdy"}, {63'd0, busy_rdy}, 64'd0);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("rst/out_valid", {63'd0, out_valid}, 64'd0);
        check("rst/in_ready", {63'd0, in_ready}, 64'd1);
        check("rst/res", result, 64'd0);
        check("rst/err", {63'd0, err}, 64'd0);
        check("rst/nzvc", {60'd0, nzvc()}, 64'd0);

        run_op("add_ovf", 4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 1, 64'h8000_0000_0000_0000, 4'b1010, 1'b0);
        release_out();
        run_op("sub_eq", 4'b0011, 64'd5, 64'd5, 1'b1, 1, 64'd0, 4'b0101, 1'b0);
        release_out();
        run_op("sub_brw", 4'b0011, 64'd0, 64'd1, 1'b1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 1'b0);
        release_out();
        run_op("lsl3", 4'b1000, 64'd1, 64'd3, 1'b1, 4, 64'd8, 4'b0000, 1'b0);
        release_out();
        run_op("lsr1", 4'b1001, 64'd3, 64'd1, 1'b1, 2, 64'd1, 4'b0001, 1'b0);
        release_out();
        run_op("lsl0", 4'b1000, 64'd5, 64'd0, 1'b1, 1, 64'd5, 4'b0000, 1'b0);
        release_out();
        run_op("lsl63", 4'b1000, 64'd3, 64'd63, 1'b1, 64, 64'h8000_0000_0000_0000, 4'b1001, 1'b0);
        release_out();
        run_op("mov0", 4'b0000, 64'd7, 64'd0, 1'b1, 1, 64'd0, 4'b0100, 1'b0);
        release_out();
        run_op("and", 4'b0100, 64'hF0, 64'h3C, 1'b1, 1, 64'h30, 4'b0000, 1'b0);
        release_out();
        run_op("or", 4'b0101, 64'hF0, 64'h0F, 1'b0, 1, 64'hFF, 4'b0000, 1'b0);
        release_out();
        run_op("presetN", 4'b0011, 64'd0, 64'd1, 1'b1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 1'b0);
        release_out();
        run_op("mul_nf", 4'b1010, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b0, 65, 64'hFFFF_FFFE_0000_0001, 4'b1000, 1'b0);
        release_out();

        run_op("xor", 4'b0110, 64'hF0, 64'hFF, 1'b0, 1, 64'h0F, 4'b1000, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("bp/res", result, 64'h0F);
        check("bp/out_valid", {63'd0, out_valid}, 64'd1);
        check("bp/in_ready", {63'd0, in_ready}, 64'd0);
        release_out();
        check("bp/in_ready_after", {63'd0, in_ready}, 64'd1);
        run_op("add_after_bp", 4'b0010, 64'd2, 64'd3, 1'b0, 1, 64'd5, 4'b1000, 1'b0);
        release_out();
        run_op("mul_f", 4'b1010, 64'd3, 64'd5, 1'b1, 65, 64'd15, 4'b0000, 1'b0);
        release_out();

        run_op("presetN2", 4'b0011, 64'd0, 64'd1, 1'b1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 1'b0);
        release_out();
        cntrl = 4'b1010; A = '1; B = '1; set_flags = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort/out_valid", {63'd0, out_valid}, 64'd0);
        check("abort/res", result, 64'd0);
        check("abort/nzvc", {60'd0, nzvc()}, 64'd0);
        check("abort/in_ready", {63'd0, in_ready}, 64'd1);
        run_op("ill0111_clr", 4'b0111, 64'd9, 64'd9, 1'b1, 1, 64'd0, 4'b0000, 1'b1);
        release_out();
        run_op("presetN3", 4'b0011, 64'd0, 64'd1, 1'b1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 1'b0);
        release_out();
        run_op("ill1111", 4'b1111, 64'd1, 64'd2, 1'b1, 1, 64'd0, 4'b1000, 1'b1);
        release_out();
        run_op("err_clear", 4'b0010, 64'd1, 64'd1, 1'b1, 1, 64'd2, 4'b0000, 1'b0);
        release_out();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, multi-cycle successor to the combinational datapath ALU. It adds a valid/ready handshake on both sides, registered result and flag outputs, iterative logical shifts and an iterative shift-add multiply. It sits in the execute stage and lets the control FSM stall on long operations.

Parameters:
WIDTH, 64, operand/result width in bits (power of two, >= 8).
SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  operation request
in_ready  output  1  block can accept a request this cycle
cntrl  input  4  opcode (see Behaviour)
A  input  WIDTH  operand A
B  input  WIDTH  operand B; low SHW bits are the shift amount for shifts
set_flags  input  1  update flag register when this op completes
out_valid  output  1  result available
out_ready  input  1  consumer takes result
result  output  WIDTH  registered result
err  output  1  qualified by out_valid; illegal opcode
negative, zero, overflow, carry_out  output  1 each  registered NZVC flag register

Behaviour:
- Opcodes:
  - 0000 MOV (B)
  - 0010 ADD (A+B)
  - 0011 SUB (A-B)
  - 0100 AND
  - 0101 OR
  - 0110 XOR
  - 1000 LSL (A<<B[SHW-1:0])
  - 1001 LSR (logical, A>>B[SHW-1:0])
  - 1010 MUL (low WIDTH bits of A*B, unsigned/two's-complement identical)
  - All other codes are illegal.
- Reset:
  - state=IDLE, in_ready=1 (from next cycle), out_valid=0, result=0, err=0, N=Z=V=C=0.
  - Internal counter and operand registers are cleared.
  - Reset mid-operation aborts the op; no flag update occurs.
- FSM states: IDLE, SHIFT, MUL, DONE.
- IDLE:
  - in_ready=1.
  - in_valid accepts the op: latch A, B, cntrl, set_flags.
  - Single-cycle ops and illegal codes go to DONE.
  - LSL/LSR with amount 0 go to DONE with result=A and C=0.
  - LSL/LSR with amount n>0 go to SHIFT with count=n.
  - MUL goes to MUL with count=WIDTH.
- SHIFT:
  - One bit position per cycle; count decrements each cycle.
  - At count=1 -> DONE.
  - C = last bit shifted out.
- MUL:
  - Each cycle: if multiplier LSB=1, add multiplicand into accumulator (mod 2^WIDTH); multiplicand<<1, multiplier>>1, count decrements.
  - At count=1 -> DONE.
- DONE:
  - out_valid=1; in_ready=0; result and err held stable.
  - On out_ready -> IDLE; in_ready=1 the following cycle (no same-cycle re-accept).
- Latency (acceptance edge to out_valid high):
  - Single-cycle ops: 1 cycle.
  - Shift by n>0: n+1 cycles.
  - MUL: WIDTH+1 cycles.
- Flags:
  - Written on the edge entering DONE, only if latched set_flags=1 and the opcode is legal; otherwise held.
  - N = result[WIDTH-1]; Z = (result==0).
  - ADD: C = carry out of MSB; V = signed overflow.
  - SUB: computed as A+~B+1; C=1 means no borrow (A>=B unsigned); V = signed overflow.
  - MOV/AND/OR/XOR/MUL: C=0, V=0.
  - Shifts: C as above, V=0.
- Illegal opcode: result=0, err=1, 1-cycle latency, flags unchanged.
- in_valid while not in IDLE is ignored; the requester must hold the request until it sees in_ready.
- Arithmetic wraps mod 2^WIDTH; no saturation.

Test Plan:
- WIDTH=64, ADD A=0x7FFF_FFFF_FFFF_FFFF, B=1, set_flags=1 -> out_valid exactly 1 cycle after accept; result=0x8000_0000_0000_0000, N=1, Z=0, V=1, C=0.
- SUB A=5, B=5, set_flags=1 -> result=0, Z=1, C=1, V=0, N=0. Then SUB A=0, B=1 -> result=0xFFFF_FFFF_FFFF_FFFF, N=1, C=0.
- LSL A=1, B=3 -> result=8, out_valid 4 cycles after accept, C=0. LSR A=3, B=1 -> result=1, C=1. LSL A=5, B=0 -> result=5, 1-cycle latency.
- MUL A=B=0xFFFF_FFFF with set_flags=0, flags preset to N=1 -> result=0xFFFF_FFFE_0000_0001 at cycle 65; flags unchanged; in_ready=0 throughout.
- Back-pressure: complete XOR 0xF0^0xFF, hold out_ready=0 for 5 cycles -> result=0x0F stable, out_valid=1, in_ready=0. Pulse out_ready -> IDLE; the next in_valid is accepted.
- Start MUL, assert reset at cycle 10 -> next cycle out_valid=0, result=0, flags 0, in_ready=1. Then issue cntrl=0111 -> err=1, result=0, flags held.
